imem_arbiter: RTL and testbench

Arbitrates the single-port synchronous instruction memory between the fetch stage (read-only, nearly every cycle) and the loader/debug port (reads and writes for program load and inspection). It grants one requester per cycle and drives the memory port. It stalls fetch through `if_stall`, which the fetch stage ORs into its hazard input. It also supports a locked loader burst that holds the core off the memory for a full program download.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_starve_cnt.sv | 41 ++++
 rtl/imem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_imem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory arbiter slice.
//   imem_arb_state_t : arbiter FSM states (IDLE, FETCH, LOADER, LOCK)
//   OWN_IF / OWN_LD  : owner tag values used to steer read data back
//   IMEM_ADDR_W      : default word-address width of the instruction memory
// ---------------------------------------------------------------------------
package imem_pkg;

    // Arbiter states: who won the memory last, or exclusive loader ownership
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        LOADER = 2'd2,
        LOCK   = 2'd3
    } imem_arb_state_t;

    // Owner tag of the read currently returning from the memory
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LD = 1'b1;

    localparam int IMEM_ADDR_W = 8;

endpackage

// File: rtl/imem_starve_cnt.sv
// ---------------------------------------------------------------------------
// imem_starve_cnt
// Saturating count of consecutive cycles in which the loader asked for the
// memory and was refused. When the count reaches STARVE_MAX the loader is
// forced a grant on the following cycle.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   i_ld_req    : loader is requesting this cycle
//   i_ld_gnt    : loader was granted this cycle
//   o_force     : count has reached STARVE_MAX, loader must win now
// ---------------------------------------------------------------------------
module imem_starve_cnt #(
    parameter int STARVE_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ld_req,
    input  logic i_ld_gnt,
    output logic o_force
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_cnt;

    // Count refused loader cycles; any grant or idle loader restarts the run,
    // and the count sticks at the maximum until the forced grant clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_ld_gnt || !i_ld_req) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force = (r_cnt == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Shares the single-port synchronous instruction memory between the fetch
// stage and the loader/debug port. One requester is granted per cycle; fetch
// is held off through if_stall. A locked loader burst keeps the core off the
// memory until the loader drops both ld_lock and ld_req.
// Build option:
//   IMEM_ARB_STARVE_EN : when defined, a loader refused STARVE_MAX cycles in
//                        a row is forced a grant; otherwise fetch has strict
//                        priority outside LOCK.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   if_req, if_addr                   : fetch read request
//   if_stall                          : fetch refused this cycle (comb)
//   if_rdata, if_rvalid               : fetch read return, one cycle later
//   ld_req, ld_we, ld_lock            : loader request, write, exclusive hold
//   ld_addr, ld_wdata                 : loader address and write data
//   ld_gnt                            : loader accepted this cycle (comb)
//   ld_rdata, ld_rvalid               : loader read return, one cycle later
//   mem_en, mem_we, mem_addr,
//   mem_wdata, mem_rdata              : memory port
// ---------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W     = IMEM_ADDR_W,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_stall,
    output logic [31:0]       if_rdata,
    output logic              if_rvalid,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic              ld_lock,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic [31:0]       ld_rdata,
    output logic              ld_rvalid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    imem_arb_state_t r_state;
    imem_arb_state_t w_next_state;

    logic        w_if_win;
    logic        w_ld_win;
    logic        w_starve_force;
    logic        r_rd_pend;
    logic        r_owner;
    logic        w_if_ret;
    logic        w_ld_ret;
    logic [31:0] r_if_hold;
    logic [31:0] r_ld_hold;

`ifdef IMEM_ARB_STARVE_EN
    imem_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_ld_req (ld_req),
        .i_ld_gnt (w_ld_win),
        .o_force  (w_starve_force)
    );
`else
    // No starvation guard: the force term is always false, so fetch keeps
    // strict priority (the compare only keeps STARVE_MAX referenced)
    assign w_starve_force = (STARVE_MAX < 0);
`endif

    // State register: remembers who won last, or that the loader holds LOCK
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant and next-state logic. In LOCK only the loader may use the memory
    // and the lock persists until the loader lets go of both lock and request.
    // Elsewhere fetch wins unless it is idle, the loader is being starved, or
    // the loader just won and is asking to lock.
    always_comb begin
        w_ld_win     = 1'b0;
        w_if_win     = 1'b0;
        w_next_state = IDLE;
        if (r_state == LOCK) begin
            w_ld_win = ld_req;
            if (w_ld_win) begin
                w_next_state = ld_lock ? LOCK : LOADER;
            end else if (ld_lock) begin
                w_next_state = LOCK;
            end else begin
                w_next_state = IDLE;
            end
        end else begin
            w_ld_win = ld_req && (!if_req || w_starve_force ||
                                  (r_state == LOADER && ld_lock));
            w_if_win = if_req && !w_ld_win;
            if (w_if_win) begin
                w_next_state = FETCH;
            end else if (w_ld_win) begin
                w_next_state = ld_lock ? LOCK : LOADER;
            end else begin
                w_next_state = IDLE;
            end
        end
    end

    assign if_stall  = if_req && !w_if_win;
    assign ld_gnt    = w_ld_win;
    assign mem_en    = w_if_win || w_ld_win;
    assign mem_we    = w_ld_win && ld_we;
    assign mem_addr  = w_ld_win ? ld_addr : if_addr;
    assign mem_wdata = w_ld_win ? ld_wdata : 32'd0;

    // Track the read in flight and who issued it, so the data coming back
    // next cycle reaches the right requester; writes never produce a return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_owner   <= OWN_IF;
        end else begin
            r_rd_pend <= mem_en && !mem_we;
            if (mem_en) begin
                r_owner <= w_ld_win ? OWN_LD : OWN_IF;
            end
        end
    end

    assign w_if_ret = r_rd_pend && (r_owner == OWN_IF);
    assign w_ld_ret = r_rd_pend && (r_owner == OWN_LD);

    // Keep a copy of each requester's last returned word so its data output
    // stays stable while the other requester owns the memory
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_hold <= 32'd0;
            r_ld_hold <= 32'd0;
        end else begin
            if (w_if_ret) begin
                r_if_hold <= mem_rdata;
            end
            if (w_ld_ret) begin
                r_ld_hold <= mem_rdata;
            end
        end
    end

    assign if_rvalid = w_if_ret;
    assign ld_rvalid = w_ld_ret;
    assign if_rdata  = w_if_ret ? mem_rdata : r_if_hold;
    assign ld_rdata  = w_ld_ret ? mem_rdata : r_ld_hold;

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
// Directed bench for imem_arbiter with a behavioural single-port synchronous
// memory. Honours IMEM_ARB_STARVE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_stall;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        ld_req;
    logic        ld_we;
    logic        ld_lock;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;
    logic [31:0] ld_rdata;
    logic        ld_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] memData [0:255];
    logic        memWritten [0:255];
    logic        memClear;

    int testsRun;
    int testsFailed;

    imem_arbiter #(
        .ADDR_W     (8),
        .STARVE_MAX (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_stall  (if_stall),
        .if_rdata  (if_rdata),
        .if_rvalid (if_rvalid),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_lock   (ld_lock),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_gnt    (ld_gnt),
        .ld_rdata  (ld_rdata),
        .ld_rvalid (ld_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Preloaded contents of a word never written during the run
    function automatic logic [31:0] preWord(input logic [7:0] a);
        return 32'hC0DE0000 | {24'd0, a};
    endfunction

    // Synchronous single-port memory: unwritten words read their preload value
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 256; i++) begin
                memWritten[i] = 1'b0;
                memData[i]    = 32'd0;
            end
            mem_rdata <= 32'd0;
        end else if (mem_en) begin
            if (mem_we) begin
                memData[mem_addr]    = mem_wdata;
                memWritten[mem_addr] = 1'b1;
            end else begin
                mem_rdata <= memWritten[mem_addr] ? memData[mem_addr] : preWord(mem_addr);
            end
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive every requester input for the coming cycle
    task automatic applyStimulus(input logic iReq, input logic [7:0] iAddr,
                                 input logic lReq, input logic lWe, input logic lLock,
                                 input logic [7:0] lAddr, input logic [31:0] lData);
        if_req   = iReq;
        if_addr  = iAddr;
        ld_req   = lReq;
        ld_we    = lWe;
        ld_lock  = lLock;
        ld_addr  = lAddr;
        ld_wdata = lData;
    endtask

    // Move to just after the next rising edge, where new inputs are driven
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int grants;
        testsRun    = 0;
        testsFailed = 0;
        memClear    = 1'b1;
        rst         = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);

        // Reset values with no requests
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstIfRvalid", {31'd0, if_rvalid}, 32'd0);
        checkOutput("rstLdRvalid", {31'd0, ld_rvalid}, 32'd0);
        checkOutput("rstIfRdata", if_rdata, 32'd0);
        checkOutput("rstLdRdata", ld_rdata, 32'd0);
        checkOutput("rstIfStall", {31'd0, if_stall}, 32'd0);
        checkOutput("rstLdGnt", {31'd0, ld_gnt}, 32'd0);
        checkOutput("rstMemEn", {31'd0, mem_en}, 32'd0);
        checkOutput("rstMemWe", {31'd0, mem_we}, 32'd0);
        memClear = 1'b0;
        rst      = 1'b0;
        advance();

        // Back-to-back fetches of 0x10..0x12
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
            @(negedge clk);
            checkOutput("fetchStall", {31'd0, if_stall}, 32'd0);
            checkOutput("fetchAddr", {24'd0, mem_addr}, 32'(8'h10 + i));
            checkOutput("fetchMemEn", {31'd0, mem_en}, 32'd1);
            if (i > 0) begin
                checkOutput("fetchRvalid", {31'd0, if_rvalid}, 32'd1);
                checkOutput("fetchRdata", if_rdata, preWord(8'(8'h10 + i - 1)));
            end
            advance();
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("fetchLastRvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("fetchLastRdata", if_rdata, preWord(8'h12));
        checkOutput("fetchNoLdRvalid", {31'd0, ld_rvalid}, 32'd0);
        advance();

        // Loader write of 0xDEADBEEF to 0x20 while fetch is idle
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("ldWrGnt", {31'd0, ld_gnt}, 32'd1);
        checkOutput("ldWrMemWe", {31'd0, mem_we}, 32'd1);
        checkOutput("ldWrMemAddr", {24'd0, mem_addr}, 32'h20);
        checkOutput("ldWrMemData", mem_wdata, 32'hDEADBEEF);
        checkOutput("ldWrStall", {31'd0, if_stall}, 32'd0);
        advance();
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("ldWrNoRvalid", {31'd0, ld_rvalid}, 32'd0);
        checkOutput("refetchStall", {31'd0, if_stall}, 32'd0);
        advance();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 32'd0);
        @(negedge clk);
        checkOutput("refetchRvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("refetchRdata", if_rdata, 32'hDEADBEEF);
        checkOutput("ldRdGnt", {31'd0, ld_gnt}, 32'd1);
        checkOutput("ldRdMemWe", {31'd0, mem_we}, 32'd0);
        advance();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("ldRdRvalid", {31'd0, ld_rvalid}, 32'd1);
        checkOutput("ldRdRdata", ld_rdata, preWord(8'h11));
        checkOutput("ifRdataHeld", if_rdata, 32'hDEADBEEF);
        checkOutput("ldRdIfRvalid", {31'd0, if_rvalid}, 32'd0);
        checkOutput("idleMemEn", {31'd0, mem_en}, 32'd0);
        checkOutput("idleStall", {31'd0, if_stall}, 32'd0);
        advance();

        // Both requesters held high with a loader read
`ifdef IMEM_ARB_STARVE_EN
        for (int c = 1; c <= 15; c++) begin
            applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 8'h30, 32'd0);
            @(negedge clk);
            checkOutput("starveDeny", {31'd0, ld_gnt}, 32'd0);
            advance();
        end
        @(negedge clk);
        checkOutput("starveForceGnt", {31'd0, ld_gnt}, 32'd1);
        checkOutput("starveForceStall", {31'd0, if_stall}, 32'd1);
        checkOutput("starveForceAddr", {24'd0, mem_addr}, 32'h30);
        advance();
        @(negedge clk);
        checkOutput("starveLdRvalid", {31'd0, ld_rvalid}, 32'd1);
        checkOutput("starveLdRdata", ld_rdata, preWord(8'h30));
        grants = 0;
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            if (ld_gnt) grants++;
            advance();
        end
        checkOutput("starveCntCleared", 32'(grants), 32'd0);
        @(negedge clk);
        checkOutput("starveForceAgain", {31'd0, ld_gnt}, 32'd1);
        advance();
`else
        applyStimulus(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 8'h30, 32'd0);
        grants = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ld_gnt) grants++;
            advance();
        end
        checkOutput("noStarveGrants", 32'(grants), 32'd0);
        @(negedge clk);
        checkOutput("noStarveIfRdata", if_rdata, preWord(8'h40));
        advance();
`endif
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        advance();

        // Locked burst of four writes to 0x50..0x53 with fetch waiting on 0x52
        for (int k = 0; k < 4; k++) begin
            applyStimulus(k > 0, 8'h52, 1'b1, 1'b1, 1'b1, 8'(8'h50 + k), 32'h5000 + k);
            @(negedge clk);
            checkOutput("lockGnt", {31'd0, ld_gnt}, 32'd1);
            checkOutput("lockMemWe", {31'd0, mem_we}, 32'd1);
            checkOutput("lockMemAddr", {24'd0, mem_addr}, 32'(8'h50 + k));
            checkOutput("lockStall", {31'd0, if_stall}, (k > 0) ? 32'd1 : 32'd0);
            advance();
        end
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b0, 1'b1, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("lockHoldStall", {31'd0, if_stall}, 32'd1);
        checkOutput("lockHoldMemEn", {31'd0, mem_en}, 32'd0);
        advance();
        applyStimulus(1'b1, 8'h52, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("lockExitStall", {31'd0, if_stall}, 32'd1);
        checkOutput("lockExitMemEn", {31'd0, mem_en}, 32'd0);
        advance();
        @(negedge clk);
        checkOutput("resumeStall", {31'd0, if_stall}, 32'd0);
        checkOutput("resumeMemAddr", {24'd0, mem_addr}, 32'h52);
        advance();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("resumeRvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("resumeRdata", if_rdata, 32'h5002);
        advance();

        // Reset asserted while a locked loader read is in flight
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 32'd0);
        @(negedge clk);
        checkOutput("lockRdGnt", {31'd0, ld_gnt}, 32'd1);
        advance();
        applyStimulus(1'b1, 8'h60, 1'b1, 1'b0, 1'b1, 8'h12, 32'd0);
        @(negedge clk);
        checkOutput("lockRdGnt2", {31'd0, ld_gnt}, 32'd1);
        checkOutput("lockRdStall", {31'd0, if_stall}, 32'd1);
        checkOutput("lockRdRvalid", {31'd0, ld_rvalid}, 32'd1);
        checkOutput("lockRdRdata", ld_rdata, preWord(8'h11));
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        #1;
        checkOutput("midRstLdRvalid", {31'd0, ld_rvalid}, 32'd0);
        checkOutput("midRstLdRdata", ld_rdata, 32'd0);
        checkOutput("midRstIfRdata", if_rdata, 32'd0);
        checkOutput("midRstMemEn", {31'd0, mem_en}, 32'd0);
        advance();
        checkOutput("midRstNoPulse", {31'd0, ld_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h13, 1'b1, 1'b0, 1'b1, 8'h14, 32'd0);
        #1;
        checkOutput("postRstStall", {31'd0, if_stall}, 32'd0);
        checkOutput("postRstLdGnt", {31'd0, ld_gnt}, 32'd0);
        checkOutput("postRstMemAddr", {24'd0, mem_addr}, 32'h13);
        advance();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0);
        @(negedge clk);
        checkOutput("postRstRvalid", {31'd0, if_rvalid}, 32'd1);
        checkOutput("postRstRdata", if_rdata, preWord(8'h13));
        checkOutput("postRstLdRvalid", {31'd0, ld_rvalid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
